stream_demultiplexer: RTL and testbench

- 1-to-4 stream demultiplexer with valid/ready handshaking.
- Routes each input word to one of four output channels, chosen by a 2-bit selector that travels with the word.
- Each output channel has its own one-entry register slice, so a stalled channel never blocks the others once its slice is empty.
- Each channel keeps a transfer counter for debug and readout.
- It is the distribution-side counterpart of the 4-to-1 Multiplexer on the 32-bit datapath.

---
 rtl/stream_demultiplexer.sv | 59 +++++
 tb/tb_stream_demultiplexer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/stream_demultiplexer.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry register slice and
// a wrapping transfer counter per output channel.
module stream_demultiplexer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [1:0]               selector,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    data0,
    output logic [DATA_WIDTH-1:0]    data1,
    output logic [DATA_WIDTH-1:0]    data2,
    output logic [DATA_WIDTH-1:0]    data3,
    output logic [3:0]               output_valid,
    input  logic [3:0]               output_ready,
    output logic [4*COUNT_WIDTH-1:0] xfer_counts
);

    logic [3:0][DATA_WIDTH-1:0]  r_data;
    logic [3:0][COUNT_WIDTH-1:0] r_cnt;
    logic [3:0]                  r_valid;
    logic                        w_accept;
    logic [3:0]                  w_drain;

    // A slice can take a new word if it is empty or is being drained this cycle.
    assign in_ready = !r_valid[selector] || output_ready[selector];
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_valid & output_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (selector == 2'(i))) begin
                    r_data[i]  <= data_in;
                    r_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_drain[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign data0        = r_data[0];
    assign data1        = r_data[1];
    assign data2        = r_data[2];
    assign data3        = r_data[3];
    assign output_valid = r_valid;
    assign xfer_counts  = r_cnt;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Randomized plus directed bench for stream_demultiplexer against a
// queue-based channel model.
module tb_stream_demultiplexer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic [1:0]    selector;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data0, data1, data2, data3;
    logic [3:0]    output_valid;
    logic [3:0]    output_ready;
    logic [4*CW-1:0] xfer_counts;

    stream_demultiplexer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .output_valid(output_valid), .output_ready(output_ready),
        .xfer_counts(xfer_counts)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (in_valid === 1'b1)
            assert (!$isunknown(selector)) else $error("selector X while in_valid");

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each channel is a FIFO of outstanding words (capacity 1), a
    // count of completed handshakes, and the last word delivered to it.
    logic [DW-1:0] mq [4][$];
    int            mcnt [4];
    logic [DW-1:0] mlast [4];
    logic          pending;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dout(input int i);
        case (i)
            0: return data0;
            1: return data1;
            2: return data2;
            default: return data3;
        endcase
    endfunction

    // Inputs are already applied (after negedge); check, then advance model
    // to what the coming posedge should produce.
    task automatic cycle();
        logic exp_rdy;
        logic acc;
        #1;
        exp_rdy = (mq[selector].size() == 0) || output_ready[selector];
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), 64'(output_valid[i]), 64'(mq[i].size() != 0));
            chk($sformatf("data%0d", i), 64'(dout(i)), 64'(mlast[i]));
            chk($sformatf("count%0d", i), 64'(xfer_counts[i*CW +: CW]), 64'(mcnt[i] % (1 << CW)));
        end
        acc = in_valid && exp_rdy;
        pending = in_valid && !exp_rdy;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                mcnt[i]  = 0;
                mlast[i] = '0;
            end
            pending = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0 && output_ready[i]) begin
                    void'(mq[i].pop_front());
                    mcnt[i]++;
                end
            if (acc) begin
                mq[selector].push_back(data_in);
                mlast[selector] = data_in;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                         input logic [3:0] rdy);
        in_valid = v; selector = s; data_in = d; output_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1; drive(0, 0, 0, 4'h0); cycle(); reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin mcnt[i] = 0; mlast[i] = '0; end
        pending = 1'b0;
        reset = 1'b1; drive(0, 0, 0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Reset values and first transfer to channel 2.
        drive(0, 0, 0, 4'hF); cycle();
        drive(1, 2, 32'hA5A5_0001, 4'hF); cycle();
        drive(0, 0, 0, 4'hF); cycle(); cycle();
        // Stalled channel 1 holds its word; refill on the draining cycle.
        drive(1, 1, 32'h11, 4'b1101); cycle();
        drive(1, 1, 32'h22, 4'b1101); cycle(); cycle(); cycle();
        drive(1, 1, 32'h22, 4'hF); cycle();
        drive(0, 0, 0, 4'hF); cycle();
        // Stalled channel 0 does not block channel 3.
        drive(1, 0, 32'h44, 4'b1110); cycle();
        drive(1, 3, 32'h33, 4'b1110); cycle();
        drive(0, 0, 0, 4'b1110); cycle();
        drive(0, 0, 0, 4'hF); cycle();
        // Back-to-back round robin.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 2'(k % 4), 32'h100 + k, 4'hF); cycle();
        end
        drive(0, 0, 0, 4'hF); cycle(); cycle();
        chk("rr_counts", 64'(xfer_counts), 64'h2222);
        // Counter wrap on channel 0.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1, 0, 32'h200 + k, 4'hF); cycle();
        end
        drive(0, 0, 0, 4'hF); cycle();
        chk("wrap_count0", 64'(xfer_counts[CW-1:0]), 64'd1);
        // Reset while a handshake is in progress.
        drive(1, 0, 32'h55, 4'h0); cycle();
        drive(1, 2, 32'h66, 4'h0); cycle();
        reset = 1'b1; drive(0, 0, 0, 4'b0001); cycle(); reset = 1'b0;
        drive(0, 0, 0, 4'h0); cycle();
        chk("post_reset_counts", 64'(xfer_counts), 64'h0);
        // Random traffic with upstream holding blocked words.
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 79) == 0);
            if (!pending)
                drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom(),
                      4'($urandom()));
            else
                output_ready = 4'($urandom());
            cycle();
        end
        reset = 1'b0; drive(0, 0, 0, 4'hF); cycle(); cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
